// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter, VGA scanout over core load/store
// Optional core starvation guard: VRAM_ARB_STARVE_GUARD_EN
module vram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 8
) (
    input  logic              ExternalClk,
    input  logic              Reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_data,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ack,
    output logic [DATA_W-1:0] core_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE    = 2'd0,
        OWN_VGA     = 2'd1,
        OWN_CORE_RD = 2'd2,
        OWN_CORE_WR = 2'd3
    } owner_t;

    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
        $error("vram_arbiter: STARVE_MAX out of range 1..255");
    end

    owner_t            r_owner;
    owner_t            w_owner_next;
    logic              r_core_busy;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [DATA_W-1:0] r_vga_data;
    logic [DATA_W-1:0] r_core_rdata;
    logic              w_core_elig;
    logic              w_force_core;
    logic              w_grant_vga;
    logic              w_grant_core;
    logic              w_vga_resp;
    logic              w_core_resp;

    assign w_core_elig = core_req & ~r_core_busy;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    logic [7:0] r_starve_cnt;

    assign w_force_core = w_core_elig && (r_starve_cnt == 8'(STARVE_MAX));

    always_ff @(posedge ExternalClk) begin
        if (Reset || w_grant_core) begin
            r_starve_cnt <= 8'd0;
        end else if (w_core_elig && w_grant_vga && (r_starve_cnt != 8'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end
`else
    assign w_force_core = 1'b0;
`endif

    // Arbitration: nothing is issued while Reset is high, which also suppresses writes.
    always_comb begin
        w_grant_vga  = 1'b0;
        w_grant_core = 1'b0;
        w_owner_next = OWN_NONE;
        if (!Reset) begin
            if (vga_req && !w_force_core) begin
                w_grant_vga  = 1'b1;
                w_owner_next = OWN_VGA;
            end else if (w_core_elig) begin
                w_grant_core = 1'b1;
                w_owner_next = core_we ? OWN_CORE_WR : OWN_CORE_RD;
            end
        end
    end

    always_comb begin
        ram_addr  = r_ram_addr;
        ram_we    = 1'b0;
        ram_wdata = r_ram_wdata;
        if (w_grant_vga) begin
            ram_addr = vga_addr;
        end else if (w_grant_core) begin
            ram_addr  = core_addr;
            ram_we    = core_we;
            ram_wdata = core_wdata;
        end
    end

    // An in-flight slot is dropped when Reset lands on its response cycle.
    assign w_vga_resp  = (r_owner == OWN_VGA) && !Reset;
    assign w_core_resp = ((r_owner == OWN_CORE_RD) || (r_owner == OWN_CORE_WR)) && !Reset;

    assign vga_valid  = w_vga_resp;
    assign vga_data   = w_vga_resp ? ram_rdata : r_vga_data;
    assign core_ack   = w_core_resp;
    assign core_rdata = (w_core_resp && (r_owner == OWN_CORE_RD)) ? ram_rdata : r_core_rdata;

    always_ff @(posedge ExternalClk) begin
        if (Reset) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_next;
        end
    end

    always_ff @(posedge ExternalClk) begin
        if (Reset) begin
            r_core_busy  <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_vga_data   <= '0;
            r_core_rdata <= '0;
        end else begin
            r_core_busy  <= w_grant_core;
            r_vga_data   <= vga_data;
            r_core_rdata <= core_rdata;
            if (w_grant_vga || w_grant_core) begin
                r_ram_addr <= ram_addr;
            end
            if (w_grant_core) begin
                r_ram_wdata <= core_wdata;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter with a cycle-level reference model
module tb_vram_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int SMAX = 8;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    localparam int K_NONE = 0;
    localparam int K_VGA  = 1;
    localparam int K_CRD  = 2;
    localparam int K_CWR  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          vga_valid;
    logic [DW-1:0] vga_data;
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_ack;
    logic [DW-1:0] core_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            prev_kind = K_NONE;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] m_last_addr = '0;
    logic [DW-1:0] m_rdata = '0;
    int            m_starve = 0;
    logic          m_ack = 1'b0;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .ExternalClk(clk),
        .Reset      (rst),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_valid  (vga_valid),
        .vga_data   (vga_data),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Synchronous RAM, 1-cycle read latency; preload port is used only while the DUT is in reset.
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst_i, input logic vreq_i, input logic [AW-1:0] vaddr_i,
                        input logic creq_i, input logic cwe_i, input logic [AW-1:0] caddr_i,
                        input logic [DW-1:0] cwd_i);
        int            kind;
        logic          busy;
        logic          elig;
        logic          force_c;
        logic [AW-1:0] exp_addr;
        @(posedge clk);
        #2;
        rst = rst_i; vga_req = vreq_i; vga_addr = vaddr_i;
        core_req = creq_i; core_we = cwe_i; core_addr = caddr_i; core_wdata = cwd_i;
        ld_en = 1'b0;
        #1;
        m_ack = !rst_i && (prev_kind == K_CRD || prev_kind == K_CWR);
        chk("vga_valid", 32'(vga_valid), 32'(!rst_i && prev_kind == K_VGA));
        chk("core_ack", 32'(core_ack), 32'(m_ack));
        if (!rst_i && prev_kind == K_VGA) chk("vga_data", 32'(vga_data), 32'(prev_data));
        if (!rst_i && prev_kind == K_CRD) begin
            chk("core_rdata", 32'(core_rdata), 32'(prev_data));
            m_rdata = prev_data;
        end
        if (!rst_i && prev_kind == K_CWR) chk("core_rdata_hold", 32'(core_rdata), 32'(m_rdata));

        // One access per two cycles for the core: the ack cycle cannot issue.
        busy    = (prev_kind == K_CRD || prev_kind == K_CWR);
        elig    = creq_i && !busy;
        force_c = GUARD && elig && (m_starve == SMAX);
        kind    = K_NONE;
        if (!rst_i) begin
            if (vreq_i && !force_c) kind = K_VGA;
            else if (elig) kind = cwe_i ? K_CWR : K_CRD;
        end
        exp_addr = (kind == K_VGA) ? vaddr_i : ((kind == K_NONE) ? m_last_addr : caddr_i);
        chk("ram_we", 32'(ram_we), 32'(kind == K_CWR));
        if (!rst_i) chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
        if (kind == K_CRD || kind == K_CWR) chk("ram_wdata", 32'(ram_wdata), 32'(cwd_i));

        case (kind)
            K_VGA: prev_data = ref_mem[vaddr_i];
            K_CRD: prev_data = ref_mem[caddr_i];
            K_CWR: ref_mem[caddr_i] = cwd_i;
            default: ;
        endcase
        if (kind != K_NONE) m_last_addr = exp_addr;
        if (kind == K_CRD || kind == K_CWR) m_starve = 0;
        else if (elig && kind == K_VGA && m_starve < SMAX) m_starve++;
        if (rst_i) begin
            m_last_addr = '0;
            m_rdata     = '0;
            m_starve    = 0;
        end
        prev_kind = kind;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vga_valid"}, 32'(vga_valid), 32'd0);
        chk({tag, "_core_ack"}, 32'(core_ack), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
        chk({tag, "_vga_data"}, 32'(vga_data), 32'd0);
        chk({tag, "_core_rdata"}, 32'(core_rdata), 32'd0);
    endtask

    logic [DW-1:0] pix [0:3];
    logic          c_active;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wd;
    int            ack_at;

    initial begin
        rst = 1'b1; vga_req = 1'b0; vga_addr = '0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        pix[0] = 8'h5A; pix[1] = 8'hC3; pix[2] = 8'h0F; pix[3] = 8'hF0;

        // Preload while held in reset: random pool 0x40..0x4F plus directed locations.
        for (int i = 0; i < 21; i++) begin
            @(posedge clk);
            #2;
            ld_en = 1'b1;
            if (i < 16) begin
                ld_addr = 16'(16'h0040 + i);
                ld_data = 8'($urandom);
            end else if (i == 16) begin
                ld_addr = 16'h0010;
                ld_data = 8'hA5;
            end else begin
                ld_addr = 16'(16'h1000 + i - 17);
                ld_data = pix[i - 17];
            end
            ref_mem[ld_addr] = ld_data;
        end
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        idle();
        chk_reset_vals("post_reset");

        // Core read with idle VGA
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'h0010, '0);
        chk("rd_issue_addr", 32'(ram_addr), 32'h0010);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'h0010, '0);
        chk("rd_ack", 32'(core_ack), 32'd1);
        chk("rd_data", 32'(core_rdata), 32'hA5);
        idle();

        // Core write then read back
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 16'h0200, 8'h3C);
        chk("wr_we", 32'(ram_we), 32'd1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 16'h0200, 8'h3C);
        chk("wr_we_once", 32'(ram_we), 32'd0);
        chk("wr_ack", 32'(core_ack), 32'd1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'h0200, '0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'h0200, '0);
        chk("rdback_data", 32'(core_rdata), 32'h3C);
        idle();

        // VGA streaming, back-to-back
        for (int i = 0; i < 5; i++) begin
            step(1'b0, i < 4, 16'(16'h1000 + i), 1'b0, 1'b0, '0, '0);
            if (i > 0) begin
                chk("stream_valid", 32'(vga_valid), 32'd1);
                chk("stream_data", 32'(vga_data), 32'(pix[i - 1]));
            end
        end
        idle();

        // Contention: VGA for 20 cycles, core read pending from cycle 0
        ack_at = -1;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, i < 20, 16'(16'h0040 + (i % 16)), 1'b1, 1'b0, 16'h0044, '0);
            if (m_ack) begin
                ack_at = i;
                break;
            end
        end
        chk("contention_ack_cycle", 32'(ack_at), GUARD ? 32'd9 : 32'd21);
        for (int i = 0; i < 22; i++) begin
            if (GUARD && ack_at >= 0 && ack_at + 1 + i < 20)
                step(1'b0, 1'b1, 16'(16'h0040 + i[3:0]), 1'b0, 1'b0, '0, '0);
        end
        idle();

        // Randomized traffic with a well-behaved core agent and occasional reset
        c_active = 1'b0; c_we = 1'b0; c_addr = '0; c_wd = '0;
        for (int i = 0; i < 400; i++) begin
            logic r;
            if (m_ack) c_active = 1'b0;
            if (!c_active && ($urandom % 3 == 0)) begin
                c_active = 1'b1;
                c_we     = 1'($urandom);
                c_addr   = 16'(16'h0040 + ($urandom % 16));
                c_wd     = 8'($urandom);
            end
            r = ($urandom % 97 == 0);
            step(r, ($urandom % 5) < 3, 16'(16'h0040 + ($urandom % 16)), c_active, c_we, c_addr, c_wd);
            if (r) c_active = 1'b0;
        end
        idle();
        idle();

        // Reset while a core read is in flight
        for (int i = 0; i < 5; i++) idle();
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'h0044, '0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'h0044, '0);
        chk("rst_mid_ack6", 32'(core_ack), 32'd0);
        chk("rst_mid_valid6", 32'(vga_valid), 32'd0);
        idle();
        chk_reset_vals("rst_mid7");
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
